// File: rtl/matrix_pkg.sv
// Shared types for the matrix memory responder: address width, FSM mode
// encoding and an address range helper.
package matrix_pkg;

    localparam int MAT_ADDR_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DUMP
    } mat_mode_t;

    typedef logic [MAT_ADDR_W-1:0] mat_addr_t;

    // True when (row, col) lies inside a rows x cols matrix.
    function automatic logic addr_in_range(input mat_addr_t row, input mat_addr_t col,
                                           input int rows, input int cols);
        return (int'(row) < rows) && (int'(col) < cols);
    endfunction

endpackage

// File: rtl/mat_storage.sv
// Matrix element storage: ROWS*COLS flop array, one write port and two
// combinational read ports (engine side and dump side). Reads of an
// out-of-range address return 0.
module mat_storage
    import matrix_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 16,
    parameter int COLS       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  mat_addr_t             wr_row,
    input  mat_addr_t             wr_col,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  mat_addr_t             eng_row,
    input  mat_addr_t             eng_col,
    output logic [DATA_WIDTH-1:0] eng_data,
    input  mat_addr_t             dump_row,
    input  mat_addr_t             dump_col,
    output logic [DATA_WIDTH-1:0] dump_data
);

    localparam int DEPTH = ROWS * COLS;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Row-major flattening of a (row, col) pair.
    function automatic logic [AW-1:0] flat(input mat_addr_t r, input mat_addr_t c);
        return AW'(int'(r) * COLS + int'(c));
    endfunction

    // Storage array: cleared on reset, single write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i[AW-1:0]] <= '0;
            end
        end else if (we) begin
            mem[flat(wr_row, wr_col)] <= wr_data;
        end
    end

    // Combinational read ports, guarded so an out-of-range address reads 0.
    always_comb begin
        eng_data  = '0;
        dump_data = '0;
        if (addr_in_range(eng_row, eng_col, ROWS, COLS)) begin
            eng_data = mem[flat(eng_row, eng_col)];
        end
        if (addr_in_range(dump_row, dump_col, ROWS, COLS)) begin
            dump_data = mem[flat(dump_row, dump_col)];
        end
    end

endmodule

// File: rtl/matrix_mem_responder.sv
// Memory-side responder for the matrix engine: services engine row/col
// reads and writes while idle, and offers host stream ports to bulk-load
// and bulk-dump the matrix in row-major order.
module matrix_mem_responder
    import matrix_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 16,
    parameter int COLS       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en_ReadMat,
    input  logic                  en_WriteMat,
    input  logic [3:0]            rowAddr,
    input  logic [3:0]            colAddr,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic [DATA_WIDTH-1:0] readData,
    input  logic                  load_start,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  dump_start,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [DATA_WIDTH-1:0] dump_data,
    output logic                  dump_last,
    output logic                  busy,
    output logic                  addrError
);

    localparam mat_addr_t LAST_ROW = mat_addr_t'(ROWS - 1);
    localparam mat_addr_t LAST_COL = mat_addr_t'(COLS - 1);

    mat_mode_t state_q, state_d;
    mat_addr_t row_q, col_q;

    logic                  idle, eng_req, eng_in_range, cnt_last;
    logic                  load_fire, dump_fire, dump_present;
    logic                  mem_we;
    mat_addr_t             mem_wr_row, mem_wr_col;
    logic [DATA_WIDTH-1:0] mem_wr_data, eng_rd, dump_rd;

    assign idle         = (state_q == IDLE);
    assign eng_req      = en_ReadMat || en_WriteMat;
    assign eng_in_range = addr_in_range(rowAddr, colAddr, ROWS, COLS);
    assign cnt_last     = (row_q == LAST_ROW) && (col_q == LAST_COL);
    assign load_fire    = (state_q == LOAD) && load_valid;
    assign dump_fire    = dump_valid && dump_ready;
    // Present a new dump element on DUMP entry, and right after each
    // handshake except the last one, so transfers run without bubbles.
    assign dump_present = (state_q == DUMP) && (!dump_valid || (dump_fire && !dump_last));

    // Host load owns the write port in LOAD; engine writes only land in IDLE.
    assign mem_we      = load_fire || (idle && en_WriteMat && eng_in_range);
    assign mem_wr_row  = load_fire ? row_q     : rowAddr;
    assign mem_wr_col  = load_fire ? col_q     : colAddr;
    assign mem_wr_data = load_fire ? load_data : writeData;

    mat_storage #(
        .DATA_WIDTH(DATA_WIDTH),
        .ROWS      (ROWS),
        .COLS      (COLS)
    ) u_storage (
        .clk      (clk),
        .rst      (reset),
        .we       (mem_we),
        .wr_row   (mem_wr_row),
        .wr_col   (mem_wr_col),
        .wr_data  (mem_wr_data),
        .eng_row  (rowAddr),
        .eng_col  (colAddr),
        .eng_data (eng_rd),
        .dump_row (row_q),
        .dump_col (col_q),
        .dump_data(dump_rd)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic plus state-decoded busy/load_ready.
    always_comb begin
        state_d    = state_q;
        busy       = 1'b0;
        load_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_start)      state_d = LOAD;
                else if (dump_start) state_d = DUMP;
            end
            LOAD: begin
                busy       = 1'b1;
                load_ready = 1'b1;
                if (load_fire && cnt_last) state_d = IDLE;
            end
            DUMP: begin
                busy = 1'b1;
                if (dump_fire && dump_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Row/col counters, engine read register, error pulse and dump output regs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q      <= '0;
            col_q      <= '0;
            readData   <= '0;
            addrError  <= 1'b0;
            dump_valid <= 1'b0;
            dump_data  <= '0;
            dump_last  <= 1'b0;
        end else begin
            addrError <= eng_req && (!idle || !eng_in_range);

            if (idle && en_ReadMat) begin
                readData <= eng_in_range ? eng_rd : '0;
            end

            if (load_fire || dump_present) begin
                if (cnt_last) begin
                    row_q <= '0;
                    col_q <= '0;
                end else if (col_q == LAST_COL) begin
                    col_q <= '0;
                    row_q <= row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end

            if (dump_present) begin
                dump_valid <= 1'b1;
                dump_data  <= dump_rd;
                dump_last  <= cnt_last;
            end else if (dump_fire) begin
                dump_valid <= 1'b0;
                dump_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_matrix_mem_responder.sv
// Scoreboard bench for matrix_mem_responder (4x4, 8-bit): stimulus pushes
// expected engine reads and dump elements into queues; a negedge monitor
// pops and compares whenever the DUT presents a result.
module tb_matrix_mem_responder;

    localparam int DW = 8;
    localparam int R  = 4;
    localparam int C  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          en_ReadMat, en_WriteMat;
    logic [3:0]    rowAddr, colAddr;
    logic [DW-1:0] writeData, readData;
    logic          load_start, load_valid, load_ready;
    logic [DW-1:0] load_data;
    logic          dump_start, dump_valid, dump_ready, dump_last;
    logic [DW-1:0] dump_data;
    logic          busy, addrError;

    always #5 clk = ~clk;

    matrix_mem_responder #(
        .DATA_WIDTH(DW),
        .ROWS      (R),
        .COLS      (C)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en_ReadMat (en_ReadMat),
        .en_WriteMat(en_WriteMat),
        .rowAddr    (rowAddr),
        .colAddr    (colAddr),
        .writeData  (writeData),
        .readData   (readData),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .dump_start (dump_start),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_data  (dump_data),
        .dump_last  (dump_last),
        .busy       (busy),
        .addrError  (addrError)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } rd_exp_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } dump_exp_t;

    rd_exp_t   rd_q[$];
    dump_exp_t dump_q[$];

    int   checks      = 0;
    int   failures    = 0;
    int   dump_pops   = 0;
    int   err_pulses  = 0;
    int   busy_cycles = 0;
    int   valid_cycles = 0;
    int   held5       = 0;
    logic rd_pending  = 1'b0;
    logic rd_check    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // A read issued before an edge is checked at the negedge after it.
    always @(posedge clk) rd_check <= rd_pending;

    // Monitor: event counters plus scoreboard pops for reads and dump elements.
    always @(negedge clk) begin
        rd_exp_t re;
        if (addrError === 1'b1) err_pulses++;
        if (busy === 1'b1) busy_cycles++;
        if (dump_valid === 1'b1) valid_cycles++;
        if (dump_valid === 1'b1 && dump_pops == 5) held5++;
        if (rd_check) begin
            if (rd_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL rd_underflow: read result with no expected entry");
            end else begin
                re = rd_q.pop_front();
                check("readData", 32'(readData), 32'(re.data));
                check("read_addrError", 32'(addrError), 32'(re.err));
            end
        end
        if (dump_valid === 1'b1) begin
            if (dump_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL dump_underflow: dump_valid with no expected element");
            end else begin
                check("dump_data", 32'(dump_data), 32'(dump_q[0].data));
                check("dump_last", 32'(dump_last), 32'(dump_q[0].last));
                if (dump_ready) begin
                    void'(dump_q.pop_front());
                    dump_pops++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic eng_read(input int r, input int c, input logic [DW-1:0] d, input logic e);
        en_ReadMat = 1'b1;
        rowAddr    = 4'(r);
        colAddr    = 4'(c);
        rd_q.push_back('{d, e});
        rd_pending = 1'b1;
        tick();
        en_ReadMat = 1'b0;
        rd_pending = 1'b0;
    endtask

    task automatic eng_write(input int r, input int c, input logic [DW-1:0] d);
        en_WriteMat = 1'b1;
        rowAddr     = 4'(r);
        colAddr     = 4'(c);
        writeData   = d;
        tick();
        en_WriteMat = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_readData"},   32'(readData),   0);
        check({tag, "_load_ready"}, 32'(load_ready), 0);
        check({tag, "_dump_valid"}, 32'(dump_valid), 0);
        check({tag, "_dump_data"},  32'(dump_data),  0);
        check({tag, "_dump_last"},  32'(dump_last),  0);
        check({tag, "_busy"},       32'(busy),       0);
        check({tag, "_addrError"},  32'(addrError),  0);
    endtask

    // Expects the matrix to hold 0..15; optionally stalls element 5 for three
    // cycles, optionally injects an engine write mid-dump.
    task automatic run_dump(input bit stall5, input bit inject_wr);
        int stall;
        int guard;
        for (int i = 0; i < R * C; i++) dump_q.push_back('{8'(i), (i == R * C - 1)});
        valid_cycles = 0;
        held5        = 0;
        dump_pops    = 0;
        stall        = 0;
        guard        = 0;
        dump_ready   = 1'b1;
        dump_start   = 1'b1;
        tick();
        dump_start = 1'b0;
        while (dump_pops < R * C && guard < 200) begin
            if (stall5 && dump_valid && dump_pops == 5 && stall < 3) begin
                dump_ready = 1'b0;
                stall++;
            end else begin
                dump_ready = 1'b1;
            end
            if (inject_wr && guard == 3) begin
                en_WriteMat = 1'b1;
                rowAddr     = 4'd0;
                colAddr     = 4'd0;
                writeData   = 8'h77;
            end else begin
                en_WriteMat = 1'b0;
            end
            tick();
            guard++;
        end
        en_WriteMat = 1'b0;
        if (dump_pops < R * C) begin
            checks++; failures++;
            $display("FAIL dump_timeout: got %0d handshakes expected %0d", dump_pops, R * C);
        end
        check("dump_done_busy",  32'(busy),       0);
        check("dump_done_valid", 32'(dump_valid), 0);
        check("dump_queue_empty", 32'(dump_q.size()), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        reset       = 1'b1;
        en_ReadMat  = 1'b0;
        en_WriteMat = 1'b0;
        rowAddr     = '0;
        colAddr     = '0;
        writeData   = '0;
        load_start  = 1'b0;
        load_valid  = 1'b0;
        load_data   = '0;
        dump_start  = 1'b0;
        dump_ready  = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Cleared memory reads 0, no error, not busy.
        eng_read(2, 3, 8'h00, 1'b0);
        check("idle_busy", 32'(busy), 0);

        // Same-cycle write and read of (2,3): read sees old value.
        en_WriteMat = 1'b1;
        writeData   = 8'hA5;
        eng_read(2, 3, 8'h00, 1'b0);
        en_WriteMat = 1'b0;
        eng_read(2, 3, 8'hA5, 1'b0);

        // Bulk load 0..15 with load_valid toggling every cycle.
        busy_cycles = 0;
        load_start  = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < R * C; i++) begin
            load_valid = 1'b0;
            tick();
            load_valid = 1'b1;
            load_data  = 8'(i);
            check("load_ready", 32'(load_ready), 1);
            tick();
        end
        load_valid = 1'b0;
        check("load_done_ready", 32'(load_ready), 0);
        check("load_done_busy",  32'(busy), 0);
        check("load_busy_cycles", 32'(busy_cycles), 32);
        eng_read(1, 2, 8'd6,  1'b0);
        eng_read(3, 3, 8'd15, 1'b0);
        eng_read(2, 3, 8'd11, 1'b0);

        // Dump with a three-cycle stall on element 5.
        run_dump(1'b1, 1'b0);
        check("dump_valid_cycles", 32'(valid_cycles), 19);
        check("dump_elem5_held", 32'(held5), 4);

        // Out-of-range accesses: read returns 0, write (0,5) must not alias (1,1).
        e0 = err_pulses;
        eng_read(5, 0, 8'h00, 1'b1);
        eng_write(0, 5, 8'hEE);
        tick();
        check("oor_err_pulses", 32'(err_pulses - e0), 2);
        eng_read(1, 1, 8'd5, 1'b0);

        // Engine write during DUMP is dropped and flagged once.
        e0 = err_pulses;
        run_dump(1'b0, 1'b1);
        check("busy_wr_err_pulses", 32'(err_pulses - e0), 1);
        eng_read(0, 0, 8'h00, 1'b0);

        // Both starts together: LOAD wins; reset mid-load clears everything.
        load_start = 1'b1;
        dump_start = 1'b1;
        tick();
        load_start = 1'b0;
        dump_start = 1'b0;
        check("both_start_load_ready", 32'(load_ready), 1);
        for (int i = 0; i < 7; i++) begin
            load_valid = 1'b1;
            load_data  = 8'(100 + i);
            tick();
        end
        load_data = 8'd107;
        reset     = 1'b1;
        #1;
        check_all_zero("midload_reset");
        tick();
        reset      = 1'b0;
        load_valid = 1'b0;
        tick();
        check("post_reset_dump_valid", 32'(dump_valid), 0);
        check("post_reset_busy", 32'(busy), 0);
        eng_read(0, 0, 8'h00, 1'b0);
        eng_read(1, 2, 8'h00, 1'b0);
        tick();
        check("read_queue_empty", 32'(rd_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
